// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART memory loader: sync byte, byte-lane
// select for a full word, FSM state encodings and the word address helper.
package uart_mem_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [3:0] SEL_WORD  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_H,
        ST_CNT_L,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Byte address of word 'index'; 32-bit arithmetic wraps naturally.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] index);
        return base + {14'd0, index, 2'b00};
    endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// Data-memory port driven by the loader (ce/we/addr/sel/data), the same
// shape as the port data_ram answers.
interface uart_mem_loader_if;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;

    modport master (output ce, we, addr, sel, data);
    modport slave  (input  ce, we, addr, sel, data);
endinterface

// File: rtl/uart_mem_loader_uart_rx_core.sv
// UART 8N1 receiver: 2-flop synchronizer, falling-edge start detection
// with a half-bit start re-check, mid-bit sampling LSB first, stop-bit
// check. Emits one byte_valid_o pulse per good byte, frame_err_o when the
// stop bit reads low.
module uart_rx_core
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_reg;
    logic          rx_prev_reg;
    logic          rx_s;
    rx_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_reg, bit_next;
    logic [7:0]    shift_reg, shift_next;
    logic          stop_mid;

    assign rx_s = sync_reg[1];

    // Synchronize the line and keep the previous sample for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], uart_rx};
            rx_prev_reg <= rx_s;
        end
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RX_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    // Bit timing: half a bit to the start-bit centre, then full bits.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_s) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_s, shift_reg[7:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    // Result pulses at the stop-bit centre.
    always_comb begin
        stop_mid     = (state_reg == RX_STOP) && (cnt_reg == LAST);
        byte_valid_o = stop_mid && rx_s;
        frame_err_o  = stop_mid && !rx_s;
        byte_o       = shift_reg;
    end

endmodule

// File: rtl/uart_mem_loader.sv
// Serial boot loader: receives a framed image over UART
// (0x55, count_hi, count_lo, N*4 big-endian data bytes, checksum) and
// writes it as 32-bit words to data memory. The CPU is held in reset
// until a load finishes with a good checksum.
// Optional macro LOADER_TIMEOUT_EN: abort to ERR when no byte arrives for
// TIMEOUT_CYCLES while a frame is in progress.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT   = 434,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    uart_mem_loader_if.master bus,
    output logic              cpu_rst_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    if (CLKS_PER_BIT < 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_mem_loader: CLKS_PER_BIT must be >= 8 and TIMEOUT_CYCLES >= 2");
    end

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          frame_err;

    loader_state_t state_reg, state_next;
    logic [15:0]   count_reg, count_next;
    logic [15:0]   index_reg, index_next;
    logic [23:0]   word_reg, word_next;     // first three bytes of the word
    logic [1:0]    byte_cnt_reg, byte_cnt_next;
    logic [7:0]    csum_reg, csum_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   data_reg, data_next;
    logic          in_frame;
    logic          waiting;
    logic          timeout;
    logic [15:0]   count_full;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst_n        (rst),
        .uart_rx      (uart_rx),
        .byte_o       (byte_data),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    assign in_frame   = (state_reg == ST_CNT_H) || (state_reg == ST_CNT_L) ||
                        (state_reg == ST_DATA)  || (state_reg == ST_WRITE) ||
                        (state_reg == ST_CSUM);
    assign waiting    = in_frame && (state_reg != ST_WRITE);
    assign count_full = {count_reg[15:8], byte_data};

`ifdef LOADER_TIMEOUT_EN
    logic [31:0] idle_cnt_reg;

    // Cycles since the last byte; reloads to 1 so that ERR is entered
    // exactly TIMEOUT_CYCLES after the byte_valid pulse. Saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt_reg <= '0;
        end else if (byte_valid) begin
            idle_cnt_reg <= 32'd1;
        end else if (idle_cnt_reg < 32'(TIMEOUT_CYCLES)) begin
            idle_cnt_reg <= idle_cnt_reg + 32'd1;
        end
    end

    assign timeout = waiting && !byte_valid &&
                     (idle_cnt_reg >= 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog a stalled frame waits for reset indefinitely.
    assign timeout = 1'b0;
`endif

    // Frame state, counters, checksum and held bus values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            index_reg    <= '0;
            word_reg     <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            index_reg    <= index_next;
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_next;
            csum_reg     <= csum_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
        end
    end

    // Frame parser: header, data words, checksum, and restart on sync.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        index_next    = index_reg;
        word_next     = word_reg;
        byte_cnt_next = byte_cnt_reg;
        csum_next     = csum_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_next = ST_CNT_H;
                    csum_next  = '0;
                end
            end
            ST_CNT_H: begin
                if (byte_valid) begin
                    count_next[15:8] = byte_data;
                    state_next       = ST_CNT_L;
                end
            end
            ST_CNT_L: begin
                if (byte_valid) begin
                    count_next    = count_full;
                    index_next    = '0;
                    byte_cnt_next = '0;
                    if ({16'd0, count_full} > 32'(MAX_WORDS)) begin
                        state_next = ST_ERR;
                    end else if (count_full == 16'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_valid) begin
                    word_next     = {word_reg[15:0], byte_data};
                    csum_next     = csum_reg + byte_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = ST_WRITE;
                        addr_next  = word_addr(BASE_ADDR, index_reg);
                        data_next  = {word_reg, byte_data};
                    end
                end
            end
            ST_WRITE: begin
                index_next = index_reg + 16'd1;
                if (({1'b0, index_reg} + 17'd1) < {1'b0, count_reg}) begin
                    state_next = ST_DATA;
                end else begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (byte_valid) begin
                    state_next = (byte_data == csum_reg) ? ST_DONE : ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A bad stop bit or a stall aborts a frame in progress.
        if (in_frame && (frame_err || timeout)) begin
            state_next = ST_ERR;
        end
    end

    // Bus strobes and status decoded from the current state.
    always_comb begin
        bus.ce    = (state_reg == ST_WRITE);
        bus.we    = (state_reg == ST_WRITE);
        bus.sel   = (state_reg == ST_WRITE) ? SEL_WORD : 4'h0;
        bus.addr  = addr_reg;
        bus.data  = data_reg;
        busy_o    = in_frame;
        done_o    = (state_reg == ST_DONE);
        err_o     = (state_reg == ST_ERR);
        cpu_rst_o = (state_reg != ST_DONE);
    end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Bench for uart_mem_loader: directed and random frames, with expected
// writes and status computed from the frame format.
module tb_uart_mem_loader;

    localparam int          CPB     = 16;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          MAXW    = 1024;
    localparam int          TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;
    logic cpu_rst_o, busy_o, done_o, err_o;

    uart_mem_loader_if bus();

    uart_mem_loader #(
        .CLKS_PER_BIT   (CPB),
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .bus       (bus),
        .cpu_rst_o (cpu_rst_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        we;
    } wr_t;

    wr_t         seen_q[$];
    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          checks   = 0;
    int          failures = 0;

    // Every enabled cycle on the bus is one write record.
    always @(negedge clk) begin
        if (bus.ce === 1'b1) begin
            seen_q.push_back(wr_t'{bus.addr, bus.data, bus.sel, bus.we});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        $display("tx byte=%02h stop=%0b state: cpu_rst=%0b busy=%0b done=%0b err=%0b",
                 b, stop_bit, cpu_rst_o, busy_o, done_o, err_o);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_nwr"}, 64'(seen_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < seen_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_addr"}, 64'(seen_q[i].addr), 64'(exp_q[i].addr));
            check({tag, "_data"}, 64'(seen_q[i].data), 64'(exp_q[i].data));
            check({tag, "_we_sel"}, 64'({seen_q[i].we, seen_q[i].sel}),
                  64'({exp_q[i].we, exp_q[i].sel}));
        end
    endtask

    // Sends one full frame built from 'words' and checks writes and status.
    task automatic run_frame(input string tag, input int n, input bit bad_csum);
        logic [7:0]  sum;
        logic [15:0] n16;
        logic [7:0]  b;
        bit          good;
        sum = 8'h00;
        n16 = 16'(n);
        seen_q.delete();
        exp_q.delete();
        send_byte(8'h55, 1'b1);
        send_byte(n16[15:8], 1'b1);
        send_byte(n16[7:0], 1'b1);
        if (n <= MAXW) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--) begin
                    b   = 8'(words[i] >> (8 * k));
                    sum = sum + b;
                    send_byte(b, 1'b1);
                end
                exp_q.push_back(wr_t'{BASE + 32'(4 * i), words[i], 4'hF, 1'b1});
            end
            send_byte(bad_csum ? sum - 8'd1 : sum, 1'b1);
        end
        repeat (4) @(posedge clk);
        good = (n <= MAXW) && !bad_csum;
        $display("frame %s n=%0d csum=%02h bad=%0b writes=%0d", tag, n, sum, bad_csum, seen_q.size());
        compare_writes(tag);
        check({tag, "_status"}, 64'({cpu_rst_o, busy_o, done_o, err_o}),
              good ? 64'(4'b0010) : 64'(4'b1001));
    endtask

    initial begin
        int n;
        bit bad;

        // Reset held, then released with the line idle.
        repeat (5) @(posedge clk);
        #1;
        check("in_reset_status", 64'({cpu_rst_o, busy_o, done_o, err_o, bus.ce}), 64'(5'b10000));
        rst = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("idle_status", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1000));
        check("idle_no_writes", 64'(seen_q.size()), 64'd0);

        // Reference frame, bad checksum, then resend.
        words = '{32'h1234_5678, 32'h9ABC_DEF0};
        run_frame("tp_good", 2, 1'b0);
        run_frame("tp_bad", 2, 1'b1);
        run_frame("tp_resend", 2, 1'b0);

        // Garbage before sync from a fresh reset.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        rst = 1'b1;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h13, 1'b1);
        check("garbage_ignored", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1000));
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back($urandom);
        run_frame("after_garbage", 3, 1'b0);

        // Random frames, random checksum validity.
        for (int r = 0; r < 4; r++) begin
            n   = $urandom_range(0, 4);
            bad = 1'($urandom_range(0, 1));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_frame($sformatf("rand%0d", r), n, bad);
        end

        // Boundary counts.
        run_frame("over_max", MAXW + 1, 1'b0);
        run_frame("zero_count", 0, 1'b0);

        // Bad stop bit on the third data byte.
        seen_q.delete();
        send_byte(8'h55, 1'b1);
        check("busy_after_sync", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1100));
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        repeat (4) @(posedge clk);
        check("frame_err_status", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1001));
        check("frame_err_no_write", 64'(seen_q.size()), 64'd0);

        // Asynchronous reset in the middle of a data word.
        words = '{32'hCAFE_F00D};
        run_frame("pre_reset", 1, 1'b0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAB, 1'b1);
        #3 rst = 1'b0;
        #1;
        check("async_rst_status", 64'({cpu_rst_o, busy_o, done_o, err_o, bus.ce}), 64'(5'b10000));
        check("async_rst_bus", 64'({bus.addr, bus.data}), 64'd0);
        @(posedge clk);
        rst = 1'b1;
        words = '{32'h0BAD_BEEF};
        run_frame("after_reset", 1, 1'b0);

        // Stall after the count bytes.
        seen_q.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
`ifdef LOADER_TIMEOUT_EN
        repeat (TIMEOUT - 100) @(posedge clk);
        #1;
        check("stall_before_timeout", 64'(err_o), 64'd0);
        begin
            int waited;
            waited = 0;
            while (err_o !== 1'b1 && waited < 200) begin
                @(posedge clk);
                #1;
                waited++;
            end
            check("stall_timeout_err", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1001));
        end
`else
        repeat (3 * TIMEOUT) @(posedge clk);
        #1;
        check("stall_no_timeout", 64'({cpu_rst_o, busy_o, done_o, err_o}), 64'(4'b1100));
`endif
        check("stall_no_write", 64'(seen_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
